alu_share_arbiter: RTL
======================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand and result width.
REQ-002 Parameter OPCODE_LENGTH, 4, ALU operation code width.
REQ-003 Parameter NUM_REQ, 4, number of requesters; legal range 2..8; IDW = $clog2(NUM_REQ).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_srca, req_srcb  input  NUM_REQ*DATA_WIDTH  packed operands; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_op  input  NUM_REQ*OPCODE_LENGTH  packed operation codes; same slicing rule.
REQ-010 alu_srca, alu_srcb  output  DATA_WIDTH  operands to the shared ALU, registered.
REQ-011 alu_op  output  OPCODE_LENGTH  operation code to the shared ALU, registered.
REQ-012 alu_result  input  DATA_WIDTH  combinational result from the shared ALU.
REQ-013 rsp_valid / rsp_ready  output / input  1  response handshake.
REQ-014 rsp_id  output  IDW  index of the requester owning rsp_data.
REQ-015 rsp_data  output  DATA_WIDTH  captured ALU result.

Function
REQ-016 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-017 Accept window: state IDLE, or state RESP with rsp_ready=1.
REQ-018 In an accept window with any req_valid high, the grant goes to the first valid index at or after rr_ptr, wrapping modulo NUM_REQ; req_ready of that index only is high, combinationally, in the same cycle.
REQ-019 A transfer occurs when req_valid[g] and req_ready[g] are both high; operands and op of g are latched into alu_srca/alu_srcb/alu_op, g into rsp_id, rr_ptr becomes (g+1) mod NUM_REQ, next state EXEC.
REQ-020 EXEC lasts exactly one cycle; at its end alu_result is latched into rsp_data, rsp_valid set, next state RESP.
REQ-021 Latency: transfer in cycle T yields rsp_valid=1 in cycle T+2.
REQ-022 RESP holds rsp_valid, rsp_id, rsp_data and alu_* stable until rsp_ready=1.
REQ-023 RESP with rsp_ready=1 and no req_valid: rsp_valid clears, next state IDLE.
REQ-024 RESP with rsp_ready=1 and a new transfer (simultaneous events): response retires and new operation enters EXEC the next cycle; rsp_valid low for exactly the EXEC cycle; sustained throughput one op per 2 cycles.
REQ-025 req_ready is 0 in EXEC and in RESP while rsp_ready=0.
REQ-026 No req_valid in IDLE: state, rr_ptr and all outputs unchanged.
REQ-027 alu_* outputs retain the last issued operation after retirement (no clearing).
REQ-028 Result width is DATA_WIDTH; no extension, truncation or arithmetic in this block.

Reset
REQ-029 On reset assertion, asynchronously: state IDLE, rr_ptr 0, rsp_valid 0, rsp_id 0, rsp_data 0, alu_srca 0, alu_srcb 0, alu_op 0, statistics counters 0.
REQ-030 Reset during EXEC or RESP discards the in-flight operation; no response is produced for it.
REQ-031 req_ready is 0 while reset is high.

Configuration
REQ-032 Macro ALU_SHARE_ARBITER_STATS_EN, when defined, adds outputs stat_ops (32 bits, count of transfers) and stat_stall (32 bits, cycles in RESP with rsp_ready=0), both saturating at all-ones and reset to 0.
REQ-033 Without ALU_SHARE_ARBITER_STATS_EN, those ports and counters do not exist; all other behaviour identical.

Verification
REQ-034 Single op: reset, req 1 valid, srca=0x000000F0, srcb=0x0000000F, op=4'b0001 (OR), rsp_ready=1 -> req_ready[1] same cycle, rsp_valid at T+2, rsp_id=1, rsp_data=0x000000FF.
REQ-035 Round robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles, rsp_id follows same order.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable, req_ready all 0; rsp_ready=1 -> retire and immediate next grant.
REQ-037 Wrap: rr_ptr=3, only req 0 and req 2 valid -> req 0 granted first, then req 2.
REQ-038 Reset mid-op: assert reset in EXEC -> rsp_valid never rises for that op, all outputs 0, rr_ptr 0.
REQ-039 With ALU_SHARE_ARBITER_STATS_EN: 3 ops, one with 4 stall cycles -> stat_ops=3, stat_stall=4.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external combinational ALU between NUM_REQ requesters.
// A round-robin grant picks one valid requester per accept window, its
// operands are registered onto alu_srca/alu_srcb/alu_op, the ALU result is
// captured one cycle later and held on rsp_data until rsp_ready.
// Optional build macro: ALU_SHARE_ARBITER_STATS_EN adds the saturating
// counters stat_ops (transfers) and stat_stall (RESP cycles with rsp_ready=0).

module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 4,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    output logic [DATA_WIDTH-1:0]            alu_srca,
    output logic [DATA_WIDTH-1:0]            alu_srcb,
    output logic [OPCODE_LENGTH-1:0]         alu_op,
    input  logic [DATA_WIDTH-1:0]            alu_result,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [IDW-1:0]                   rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_data
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [31:0]                      stat_ops,
    output logic [31:0]                      stat_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;

    logic [IDW-1:0]             rr_ptr;
    logic [IDW-1:0]             rr_ptr_next;
    logic [IDW-1:0]             grant_idx;
    logic                       grant_found;
    logic                       accept_window;
    logic                       transfer;

    logic [DATA_WIDTH-1:0]      sel_srca;
    logic [DATA_WIDTH-1:0]      sel_srcb;
    logic [OPCODE_LENGTH-1:0]   sel_op;

    // A new operation may be accepted when idle, or when the held response retires this cycle
    always_comb begin
        accept_window = (state == IDLE) || ((state == RESP) && rsp_ready);
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int cand;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    // One-hot accept to the granted requester only, suppressed while reset is asserted
    always_comb begin
        req_ready = '0;
        if (!reset && accept_window && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // A transfer is the valid/ready handshake of the granted requester
    always_comb begin
        transfer = |(req_valid & req_ready);
    end

    // Operand and opcode mux for the granted requester, plus the pointer it leaves behind
    always_comb begin
        sel_srca    = req_srca[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_srcb    = req_srcb[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_op      = req_op[int'(grant_idx)*OPCODE_LENGTH +: OPCODE_LENGTH];
        rr_ptr_next = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end

    // Next-state logic: EXEC is always a single cycle, RESP waits for rsp_ready
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = transfer ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue registers: latch the granted operation; they keep the last issue after retirement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_srca <= '0;
            alu_srcb <= '0;
            alu_op   <= '0;
            rsp_id   <= '0;
            rr_ptr   <= '0;
        end else if (transfer) begin
            alu_srca <= sel_srca;
            alu_srcb <= sel_srcb;
            alu_op   <= sel_op;
            rsp_id   <= grant_idx;
            rr_ptr   <= rr_ptr_next;
        end
    end

    // Response registers: capture the ALU result at the end of EXEC, clear valid on retirement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
        end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SHARE_ARBITER_STATS_EN
    // Saturating counters: accepted transfers and back-pressured response cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (transfer && (stat_ops != '1)) begin
                stat_ops <= stat_ops + 32'd1;
            end
            if ((state == RESP) && !rsp_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
